sprite_engine: RTL and testbench
================================

Name: sprite_engine

Overview:
- Multi-sprite successor to the single 8x8 sprite block.
- Holds NUM_SPRITES independent 8-pixel-wide sprites, each with:
  - SPRITE_H bitmap rows
  - X/Y position
  - control byte: enable, flip, colour
- Prefetches each sprite's bitmap row for the next scanline during hsync, using a sequential fetch FSM.
- Emits a registered, priority-resolved pixel, colour and sprite index to the video mixer.
- Latches sprite-to-sprite collisions in a clear-on-read CPU status register.

Parameters:
- NUM_SPRITES, 4, number of sprites; range 1..8.
- SPRITE_H, 8, bitmap rows per sprite; range 1..13.
- ADDR_W, 7, CPU address width; must cover NUM_SPRITES*16 inclusive.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cs  in  1  register chip select
- rw  in  1  1 = write, 0 = read (qualified by cs)
- addr  in  ADDR_W  register address
- di  in  8  write data
- dout  out  8  read data, registered
- hpos  in  8  current horizontal pixel
- vpos  in  7  current scanline
- hsync  in  1  horizontal sync; high during blanking
- vsync  in  1  vertical sync; high during blanking
- pixel  out  1  sprite pixel opaque
- color  out  4  colour of winning sprite
- sprite_idx  out  3  index of winning sprite

Behaviour:
- Register map, per sprite i, base B = i*16:
  - B+0 .. B+SPRITE_H-1: bitmap rows. Bit dx of a row is the pixel at X+dx.
  - B+13: X.
  - B+14: Y (bits 6:0 used; bit 7 reads 0).
  - B+15: ctrl. Bit0 enable, bit1 hflip, bit2 vflip, bits 7:4 colour, bit3 reserved (reads 0).
  - Status at NUM_SPRITES*16: bit i set if sprite i took part in a collision since the last read.
  - Every other address reads 0; writes to it are ignored.
- Register writes:
  - Condition cs & rw; the write takes effect at the clk edge.
  - All sprite registers reset to 0 (all sprites disabled).
- Register reads:
  - Condition cs & ~rw; dout updates on the next clk edge and otherwise holds.
  - dout resets to 0.
- Status read side effect:
  - Reading status returns the current value, then clears it.
  - A collision detected in the same cycle as the clear survives: set wins over clear.
- Fetch FSM states: IDLE, FETCH, DONE.
  - IDLE -> FETCH on the rising edge of hsync, detected with a registered copy of hsync. Index k = 0.
  - FETCH processes sprite k, then increments k. After k = NUM_SPRITES-1 it goes to DONE. The fetch takes exactly NUM_SPRITES cycles.
  - DONE -> IDLE when hsync is low.
  - hsync falling before the fetch completes does not abort the fetch.
- Per-sprite fetch (sprite k):
  - dy = (vpos + 1 - Y) mod 128, i.e. the next line.
  - If enable and dy < SPRITE_H: row_buf[k] = bitmap[vflip ? SPRITE_H-1-dy : dy]. Otherwise row_buf[k] = 0.
  - ctrl and X are latched with row_buf[k] into line registers. CPU writes during active video therefore affect the next line only.
  - A CPU write to sprite k in the same cycle as its fetch: the fetch uses the old value.
- Pixel path (every cycle hsync is low):
  - dx = (hpos - X_k) mod 256.
  - Sprite k is hit if dx < 8 and row_buf[k] bit (hflip ? 7-dx : dx) is 1.
  - Winner = lowest hit index.
  - pixel, color and sprite_idx are registered: they are valid 1 clk after the hpos they correspond to.
  - No hit: pixel = 0, color = 0, sprite_idx = 0.
- Output gating:
  - During hsync or vsync, pixel = 0 and no collisions are detected.
  - vsync high also clears all row_buf entries, so no sprite shows on the first line after vsync until it has been fetched.
- Collision:
  - Two or more hits in the same cycle set the status bits of every hit sprite.
- Wrap-around:
  - A sprite at X = 252 shows at hpos 252..255 and 0..3, per the mod arithmetic.
  - Y wraps at 128 the same way.
- Reset:
  - Returns the FSM to IDLE, clears row_buf, status, dout, pixel, color and sprite_idx.
  - Reset mid-fetch abandons the fetch.

Test Plan:
- Sprite 0: X = 10, Y = 5, row0 = 0x81, ctrl = 0x31. Run the hsync of line 4, then line 5 active -> pixel = 1 with color = 3, sprite_idx = 0, one clk after hpos 10 and after hpos 17. Pixel = 0 at hpos 11..16 and on line 4.
- Same sprite with hflip (ctrl = 0x33) and row0 = 0x01 -> pixel at hpos 17 only. With vflip on, SPRITE_H = 8, row7 = 0xFF -> a full 8-pixel run on line 5.
- Sprites 0 and 2 overlapping at X = 20, both opaque. Sprite 0 colour 1, sprite 2 colour 5 -> output color = 1, sprite_idx = 0. Status read returns 0x05; a second read returns 0x00.
- Collision in the same cycle as a status read -> the read returns the old value, and the next read returns the new bits (set beats clear).
- Fetch timing, NUM_SPRITES = 4 -> FSM stays in FETCH for exactly 4 cycles after the hsync rise. Write X during fetch at k = 1 -> the write applies to the next line, not the current one.
- Wrap and reset:
  - X = 254 -> pixels at hpos 254, 255, 0..5 when row = 0xFF.
  - Assert reset mid-FETCH -> outputs 0, status 0, FSM IDLE. The next hsync refetches normally.

Source files
------------

// File: rtl/sprite_engine.sv
// sprite_engine: NUM_SPRITES 8-pixel-wide sprites, with each line's rows prefetched during hsync,
// a priority-resolved registered pixel output, and a clear-on-read collision status register.
module sprite_engine #(
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_H    = 8,
  parameter int ADDR_W      = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        di,
  output logic [7:0]        dout,
  input  logic [7:0]        hpos,
  input  logic [6:0]        vpos,
  input  logic              hsync,
  input  logic              vsync,
  output logic              pixel,
  output logic [3:0]        color,
  output logic [2:0]        sprite_idx
);
  // state    | meaning
  // ST_IDLE  | waiting for a rising edge of hsync
  // ST_FETCH | loading the line registers of sprite fetch_k
  // ST_DONE  | line fully fetched, waiting for hsync to drop
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam logic [IDX_W-1:0]  LAST_K      = IDX_W'(NUM_SPRITES - 1);
  localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(NUM_SPRITES * 16);

  logic [7:0] bitmap [NUM_SPRITES][SPRITE_H];
  logic [7:0] pos_x  [NUM_SPRITES];
  logic [6:0] pos_y  [NUM_SPRITES];
  logic [7:0] ctrl   [NUM_SPRITES];

  logic [7:0] row_buf    [NUM_SPRITES];
  logic [7:0] line_x     [NUM_SPRITES];
  logic       line_hflip [NUM_SPRITES];
  logic [3:0] line_color [NUM_SPRITES];

  logic [NUM_SPRITES-1:0] spr_sel;
  logic [NUM_SPRITES-1:0] status;
  logic [7:0]             rd_data;
  logic                   status_rd;

  logic [1:0]       state;
  logic [IDX_W-1:0] fetch_k;
  logic             hsync_q;

  logic [7:0] f_x;
  logic [6:0] f_y;
  logic       f_en;
  logic       f_hflip;
  logic       f_vflip;
  logic [3:0] f_color;
  logic [6:0] f_dy;
  logic [6:0] f_ridx;
  logic [7:0] f_row;

  logic                   active;
  logic [7:0]             dx [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] hits;
  logic [2:0]             win_idx;
  logic [3:0]             win_color;

  always_comb begin
    for (int i = 0; i < NUM_SPRITES; i++) begin
      spr_sel[i] = (addr[ADDR_W-1:4] == (ADDR_W-4)'(i));
    end
  end

  assign status_rd = cs && !rw && (addr == STATUS_ADDR);

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (spr_sel[i]) begin
        for (int r = 0; r < SPRITE_H; r++) begin
          if (addr[3:0] == 4'(r)) rd_data = bitmap[i][r];
        end
        case (addr[3:0])
          4'd13:   rd_data = pos_x[i];
          4'd14:   rd_data = {1'b0, pos_y[i]};
          4'd15:   rd_data = ctrl[i];
          default: ;
        endcase
      end
    end
    if (addr == STATUS_ADDR) rd_data[NUM_SPRITES-1:0] = status;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        for (int r = 0; r < SPRITE_H; r++) bitmap[i][r] <= '0;
        pos_x[i] <= '0;
        pos_y[i] <= '0;
        ctrl[i]  <= '0;
      end
    end else if (cs && rw) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (spr_sel[i]) begin
          for (int r = 0; r < SPRITE_H; r++) begin
            if (addr[3:0] == 4'(r)) bitmap[i][r] <= di;
          end
          case (addr[3:0])
            4'd13:   pos_x[i] <= di;
            4'd14:   pos_y[i] <= di[6:0];
            4'd15:   ctrl[i]  <= {di[7:4], 1'b0, di[2:0]};
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      fetch_k <= '0;
      hsync_q <= 1'b0;
    end else begin
      hsync_q <= hsync;
      case (state)
        ST_IDLE: begin
          if (hsync && !hsync_q) begin
            state   <= ST_FETCH;
            fetch_k <= '0;
          end
        end
        ST_FETCH: begin
          if (fetch_k == LAST_K) state <= ST_DONE;
          else fetch_k <= fetch_k + IDX_W'(1);
        end
        ST_DONE: begin
          if (!hsync) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Row selection for the next scanline; 7-bit arithmetic gives the Y wrap at 128.
  always_comb begin
    f_x     = '0;
    f_y     = '0;
    f_en    = 1'b0;
    f_hflip = 1'b0;
    f_vflip = 1'b0;
    f_color = '0;
    f_row   = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (fetch_k == IDX_W'(i)) begin
        f_x     = pos_x[i];
        f_y     = pos_y[i];
        f_en    = ctrl[i][0];
        f_hflip = ctrl[i][1];
        f_vflip = ctrl[i][2];
        f_color = ctrl[i][7:4];
      end
    end
    f_dy   = vpos + 7'd1 - f_y;
    f_ridx = f_vflip ? 7'(SPRITE_H - 1) - f_dy : f_dy;
    if (f_en && f_dy < 7'(SPRITE_H)) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        for (int r = 0; r < SPRITE_H; r++) begin
          if (fetch_k == IDX_W'(i) && f_ridx == 7'(r)) f_row = bitmap[i][r];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        row_buf[i]    <= '0;
        line_x[i]     <= '0;
        line_hflip[i] <= 1'b0;
        line_color[i] <= '0;
      end
    end else begin
      if (state == ST_FETCH) begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
          if (fetch_k == IDX_W'(i)) begin
            row_buf[i]    <= f_row;
            line_x[i]     <= f_x;
            line_hflip[i] <= f_hflip;
            line_color[i] <= f_color;
          end
        end
      end
      if (vsync) begin
        for (int i = 0; i < NUM_SPRITES; i++) row_buf[i] <= '0;
      end
    end
  end

  assign active = !hsync && !vsync;

  // 8-bit subtraction gives the X wrap at 256; lowest index wins.
  always_comb begin
    hits      = '0;
    win_idx   = '0;
    win_color = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      dx[i] = hpos - line_x[i];
      if (active && dx[i] < 8'd8) begin
        hits[i] = row_buf[i][line_hflip[i] ? 3'd7 - dx[i][2:0] : dx[i][2:0]];
      end
    end
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hits[i]) begin
        win_idx   = 3'(i);
        win_color = line_color[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pixel      <= 1'b0;
      color      <= '0;
      sprite_idx <= '0;
      status     <= '0;
      dout       <= '0;
    end else begin
      pixel      <= |hits;
      color      <= win_color;
      sprite_idx <= win_idx;
      status     <= (status_rd ? '0 : status) | (($countones(hits) > 1) ? hits : '0);
      if (cs && !rw) dout <= rd_data;
    end
  end

endmodule

// File: tb/tb_sprite_engine.sv
// Directed bench for sprite_engine with a line-level reference model checked every cycle.
module tb_sprite_engine;
  localparam int N  = 4;
  localparam int H  = 8;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          reset, cs, rw, hsync, vsync;
  logic [AW-1:0] addr;
  logic [7:0]    di, dout, hpos;
  logic [6:0]    vpos;
  logic          pixel;
  logic [3:0]    color;
  logic [2:0]    sprite_idx;

  always #5 clk = ~clk;

  sprite_engine #(.NUM_SPRITES(N), .SPRITE_H(H), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .cs(cs), .rw(rw), .addr(addr), .di(di), .dout(dout),
    .hpos(hpos), .vpos(vpos), .hsync(hsync), .vsync(vsync),
    .pixel(pixel), .color(color), .sprite_idx(sprite_idx)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: shadow registers, per-line copies, outputs.
  logic [7:0]   m_bm [N][H];
  logic [7:0]   m_x [N];
  logic [6:0]   m_y [N];
  logic [7:0]   m_c [N];
  logic [7:0]   l_row [N];
  logic [7:0]   l_x [N];
  logic [7:0]   l_c [N];
  logic [N-1:0] m_stat, m_hits;
  logic         m_pix, m_hs_prev, started = 1'b0;
  logic [3:0]   m_col;
  logic [2:0]   m_idx;
  logic [7:0]   m_dout;
  int           since_rise, m_dx, m_dy, m_k, m_i, m_o;

  function automatic logic [7:0] m_read(input int a);
    logic [7:0] v;
    int i, o;
    v = '0;
    i = a / 16;
    o = a % 16;
    if (a == N * 16) v[N-1:0] = m_stat;
    else if (i < N) begin
      if (o < H) v = m_bm[i][o];
      else if (o == 13) v = m_x[i];
      else if (o == 14) v = {1'b0, m_y[i]};
      else if (o == 15) v = m_c[i];
    end
    return v;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        for (int r = 0; r < H; r++) m_bm[i][r] = '0;
        m_x[i] = '0; m_y[i] = '0; m_c[i] = '0;
        l_row[i] = '0; l_x[i] = '0; l_c[i] = '0;
      end
      m_stat = '0; m_pix = 0; m_col = '0; m_idx = '0; m_dout = '0;
      since_rise = 1000; m_hs_prev = 0; started = 1'b1;
    end else begin
      m_hits = '0;
      if (!hsync && !vsync) begin
        for (int k = 0; k < N; k++) begin
          m_dx = (int'(hpos) - int'(l_x[k]) + 256) % 256;
          if (m_dx < 8) m_hits[k] = l_row[k][l_c[k][1] ? 7 - m_dx : m_dx];
        end
      end
      m_pix = (m_hits != 0);
      m_col = '0;
      m_idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
        if (m_hits[k]) begin
          m_col = l_c[k][7:4];
          m_idx = 3'(k);
        end
      end
      if (cs && !rw) begin
        m_dout = m_read(int'(addr));
        if (int'(addr) == N * 16) m_stat = '0;
      end
      if ($countones(m_hits) >= 2) m_stat = m_stat | m_hits;
      // Sprite k is fetched on the (k+1)th edge after the accepted hsync rise.
      if (since_rise < 1000) since_rise++;
      if (since_rise >= 1 && since_rise <= N) begin
        m_k  = since_rise - 1;
        m_dy = (int'(vpos) + 1 - int'(m_y[m_k]) + 256) % 128;
        if (m_c[m_k][0] && m_dy < H) l_row[m_k] = m_bm[m_k][m_c[m_k][2] ? H - 1 - m_dy : m_dy];
        else l_row[m_k] = '0;
        l_x[m_k] = m_x[m_k];
        l_c[m_k] = m_c[m_k];
      end
      if (hsync && !m_hs_prev && since_rise > N) since_rise = 0;
      if (vsync) for (int k = 0; k < N; k++) l_row[k] = '0;
      m_hs_prev = hsync;
      if (cs && rw) begin
        m_i = int'(addr) / 16;
        m_o = int'(addr) % 16;
        if (m_i < N) begin
          if (m_o < H) m_bm[m_i][m_o] = di;
          else if (m_o == 13) m_x[m_i] = di;
          else if (m_o == 14) m_y[m_i] = di[6:0];
          else if (m_o == 15) m_c[m_i] = di & 8'hF7;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("pixel", pixel, m_pix);
      check("color", color, m_col);
      check("sprite_idx", sprite_idx, m_idx);
      check("dout", dout, m_dout);
    end
  end

  // Directed stimulus; inputs change on the falling edge.
  logic [255:0] lp, e;
  logic [3:0]   lcol [256];
  logic [2:0]   lidx [256];
  logic [7:0]   rd_cap;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wr(input int a, input int d);
    cs = 1; rw = 1; addr = AW'(a); di = 8'(d);
    step();
    cs = 0; rw = 0;
  endtask

  task automatic rd(input int a, input logic [7:0] exp, input string nm);
    cs = 1; rw = 0; addr = AW'(a);
    step();
    cs = 0;
    check(nm, dout, exp);
  endtask

  task automatic hblank(input int v);
    vpos = 7'(v); hsync = 1;
    repeat (12) step();
    hsync = 0;
  endtask

  task automatic scan(input int v, input int rd_at);
    vpos = 7'(v); hsync = 0;
    for (int h = 0; h < 256; h++) begin
      hpos = 8'(h);
      if (h == rd_at) begin cs = 1; rw = 0; addr = AW'(N * 16); end
      else cs = 0;
      step();
      lp[h] = pixel; lcol[h] = color; lidx[h] = sprite_idx;
      if (h == rd_at) rd_cap = dout;
    end
    cs = 0;
  endtask

  initial begin
    reset = 1; cs = 0; rw = 0; addr = '0; di = '0; hpos = '0; vpos = '0; hsync = 0; vsync = 0;
    repeat (3) step();
    check("rst_pixel", pixel, 1'b0);
    check("rst_color", color, 4'd0);
    check("rst_idx", sprite_idx, 3'd0);
    check("rst_dout", dout, 8'd0);
    reset = 0;

    wr(0, 8'h81); wr(13, 10); wr(14, 5); wr(15, 8'h31);
    rd(13, 8'd10, "rd_x0");
    rd(15, 8'h31, "rd_ctrl0");
    hblank(3); scan(4, -1);
    check("line4_empty", lp, '0);
    hblank(4); scan(5, -1);
    e = '0; e[10] = 1; e[17] = 1;
    check("basic_line", lp, e);
    check("basic_col10", lcol[10], 4'd3);
    check("basic_col17", lcol[17], 4'd3);
    check("basic_idx10", lidx[10], 3'd0);

    wr(15, 8'h33); wr(0, 8'h01);
    hblank(4); scan(5, -1);
    e = '0; e[17] = 1;
    check("hflip_line", lp, e);
    wr(7, 8'hFF); wr(15, 8'h35);
    hblank(4); scan(5, -1);
    e = '0; e[17:10] = 8'hFF;
    check("vflip_line", lp, e);

    wr(0, 8'h01); wr(13, 20); wr(15, 8'h11);
    wr(32, 8'h01); wr(45, 20); wr(46, 5); wr(47, 8'h51);
    hblank(4); scan(5, -1);
    e = '0; e[20] = 1;
    check("overlap_line", lp, e);
    check("overlap_col", lcol[20], 4'd1);
    check("overlap_idx", lidx[20], 3'd0);
    rd(N * 16, 8'h05, "status_rd1");
    rd(N * 16, 8'h00, "status_rd2");

    hblank(4); scan(5, 20);
    check("status_same_cycle", rd_cap, 8'h00);
    rd(N * 16, 8'h05, "status_set_wins");
    rd(N * 16, 8'h00, "status_cleared");

    wr(16, 8'h01); wr(29, 40); wr(30, 5); wr(31, 8'h71);
    vpos = 7'd4; hsync = 1;
    step(); step();
    cs = 1; rw = 1; addr = AW'(29); di = 8'd60;
    step();
    cs = 0; rw = 0;
    repeat (9) step();
    hsync = 0;
    scan(5, -1);
    e = '0; e[20] = 1; e[40] = 1;
    check("fetch_old_x", lp, e);
    check("spr1_col", lcol[40], 4'd7);
    check("spr1_idx", lidx[40], 3'd1);
    hblank(4); scan(5, -1);
    e = '0; e[20] = 1; e[60] = 1;
    check("fetch_new_x", lp, e);

    wr(31, 0); wr(47, 0);
    wr(0, 8'hFF); wr(13, 254); wr(14, 5); wr(15, 8'h11);
    hblank(4); scan(5, -1);
    e = '0; e[255:254] = 2'b11; e[5:0] = 6'h3F;
    check("xwrap_line", lp, e);
    check("xwrap_col0", lcol[0], 4'd1);
    wr(14, 0);
    hblank(127); scan(0, -1);
    check("ywrap_line", lp, e);

    wr(10, 8'hAA); rd(10, 8'h00, "rd_unused");
    rd(100, 8'h00, "rd_outside");
    wr(15, 8'hFF); rd(15, 8'hF7, "rd_ctrl_mask");
    wr(14, 8'hFF); rd(14, 8'h7F, "rd_y_mask");

    vpos = 7'd4; hsync = 1;
    step(); step();
    reset = 1; hsync = 0;
    step();
    check("midrst_pixel", pixel, 1'b0);
    check("midrst_color", color, 4'd0);
    check("midrst_dout", dout, 8'd0);
    reset = 0;
    rd(N * 16, 8'h00, "midrst_status");
    rd(13, 8'h00, "midrst_x");
    scan(5, -1);
    check("midrst_line", lp, '0);
    wr(0, 8'h01); wr(13, 30); wr(14, 5); wr(15, 8'h91);
    hblank(4); scan(5, -1);
    e = '0; e[30] = 1;
    check("refetch_line", lp, e);
    check("refetch_col", lcol[30], 4'd9);

    vsync = 1;
    repeat (3) step();
    vsync = 0;
    scan(5, -1);
    check("vsync_clear", lp, '0);
    hblank(4); scan(5, -1);
    check("after_vsync", lp, e);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
